// File: rtl/uart_pkg.sv
// Shared types, line levels and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic        UART_IDLE_LVL  = 1'b1;
  localparam logic        UART_START_LVL = 1'b0;
  localparam logic        UART_STOP_LVL  = 1'b1;
  localparam int unsigned MIN_BIT_PERIOD = 32'd2;

  // Even parity over the low nbits of data; higher bits are ignored.
  function automatic logic even_parity(input logic [15:0] data, input logic [3:0] nbits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(nbits)) begin
        p = p ^ data[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Programmable up-counter running 1..rollover_val, with a restart-to-1 clear.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_r;

  // Count register; clear restarts at 1 so the first cycle of a period reads as 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r <= {NUM_CNT_BITS{1'b0}};
    end else if (clear) begin
      count_r <= NUM_CNT_BITS'(1);
    end else if (count_enable) begin
      if (count_r == rollover_val) begin
        count_r <= NUM_CNT_BITS'(1);
      end else begin
        count_r <= count_r + NUM_CNT_BITS'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign rollover_flag = count_enable && (count_r == rollover_val);

endmodule

// File: rtl/tx_timer.sv
// Bit timing for uart_tx: per-bit period counter plus data-bit counter.
module tx_timer #(
  parameter int PERIOD_BITS = 14
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [3:0]             nbits,
  output logic                   bit_tick,
  output logic                   bits_done
);

  flex_counter #(.NUM_CNT_BITS(PERIOD_BITS)) u_period_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .count_enable  (1'b1),
    .rollover_val  (period),
    .rollover_flag (bit_tick)
  );

  // Only advances on a bit boundary, so its flag marks the end of the last data bit.
  flex_counter #(.NUM_CNT_BITS(4)) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .count_enable  (bit_tick),
    .rollover_val  (nbits),
    .rollover_flag (bits_done)
  );

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Parity bit is present only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 8,
  parameter int PERIOD_BITS   = 14
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     tx_start,
  input  logic [MAX_DATA_BITS-1:0] tx_data,
  input  logic [PERIOD_BITS-1:0]   bit_period,
  input  logic [3:0]               data_size,
  output logic                     tx_out,
  output logic                     tx_busy,
  output logic                     tx_done
);

  tx_state_t                state_r, state_n_s;
  logic [MAX_DATA_BITS-1:0] shift_r, shift_n_s;
  logic [PERIOD_BITS-1:0]   period_r, period_cap_s;
  logic [3:0]               nbits_r, nbits_cap_s;
  logic                     tx_out_r, tx_busy_r, tx_done_r;
  logic                     tx_out_n_s, done_n_s, capture_s;
  logic                     timer_clear_s, bit_tick_s, bits_done_s;
`ifdef UART_TX_PARITY_EN
  logic                     parity_r;
`endif

  assign period_cap_s = (bit_period < PERIOD_BITS'(MIN_BIT_PERIOD)) ?
                        PERIOD_BITS'(MIN_BIT_PERIOD) : bit_period;
  assign nbits_cap_s  = (data_size >= 4'd5 && data_size <= 4'(MAX_DATA_BITS)) ?
                        data_size : 4'(MAX_DATA_BITS);

  // Held in restart while idle and on every state change so each state starts a fresh bit.
  assign timer_clear_s = (state_r == IDLE) || (state_n_s != state_r);

  tx_timer #(.PERIOD_BITS(PERIOD_BITS)) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (timer_clear_s),
    .period    (period_r),
    .nbits     (nbits_r),
    .bit_tick  (bit_tick_s),
    .bits_done (bits_done_s)
  );

  // Next state, next shift contents and the level the line takes next cycle.
  always_comb begin
    state_n_s  = state_r;
    shift_n_s  = shift_r;
    tx_out_n_s = tx_out_r;
    done_n_s   = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_start) begin
          capture_s  = 1'b1;
          state_n_s  = START;
          tx_out_n_s = UART_START_LVL;
        end else begin
          tx_out_n_s = UART_IDLE_LVL;
        end
      end
      START: begin
        if (bit_tick_s) begin
          state_n_s  = DATA;
          tx_out_n_s = shift_r[0];
        end else begin
          state_n_s  = START;
        end
      end
      DATA: begin
        if (bit_tick_s && bits_done_s) begin
`ifdef UART_TX_PARITY_EN
          state_n_s  = PARITY;
          tx_out_n_s = parity_r;
`else
          state_n_s  = STOP;
          tx_out_n_s = UART_STOP_LVL;
`endif
        end else if (bit_tick_s) begin
          shift_n_s  = shift_r >> 1;
          tx_out_n_s = shift_r[1];
        end else begin
          state_n_s  = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick_s) begin
          state_n_s  = STOP;
          tx_out_n_s = UART_STOP_LVL;
        end else begin
          state_n_s  = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_tick_s) begin
          state_n_s  = IDLE;
          tx_out_n_s = UART_IDLE_LVL;
          done_n_s   = 1'b1;
        end else begin
          state_n_s  = STOP;
        end
      end
      default: begin
        state_n_s  = IDLE;
        tx_out_n_s = UART_IDLE_LVL;
      end
    endcase
  end

  // State, shadow copies of the request and the registered line outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= IDLE;
      shift_r   <= {MAX_DATA_BITS{1'b0}};
      period_r  <= {PERIOD_BITS{1'b0}};
      nbits_r   <= 4'd0;
      tx_out_r  <= UART_IDLE_LVL;
      tx_busy_r <= 1'b0;
      tx_done_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_n_s;
      tx_out_r  <= tx_out_n_s;
      tx_busy_r <= (state_n_s != IDLE);
      tx_done_r <= done_n_s;
      if (capture_s) begin
        shift_r  <= tx_data;
        period_r <= period_cap_s;
        nbits_r  <= nbits_cap_s;
`ifdef UART_TX_PARITY_EN
        parity_r <= even_parity(16'(tx_data), nbits_cap_s);
`endif
      end else begin
        shift_r  <= shift_n_s;
      end
    end
  end

  assign tx_out  = tx_out_r;
  assign tx_busy = tx_busy_r;
  assign tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized frames against a bit-list model.
module tb_uart_tx;

  localparam int MAXB = 8;
  localparam int PB   = 14;

  logic            clk = 1'b0;
  logic            n_rst = 1'b1;
  logic            tx_start = 1'b0;
  logic [MAXB-1:0] tx_data = 8'h00;
  logic [PB-1:0]   bit_period = 14'd10;
  logic [3:0]      data_size = 4'd8;
  logic            tx_out, tx_busy, tx_done;

  int checks = 0;
  int failures = 0;

  bit exp_bits[$];
  int exp_p;

  always #5 clk = ~clk;

  uart_tx #(.MAX_DATA_BITS(MAXB), .PERIOD_BITS(PB)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .bit_period (bit_period),
    .data_size  (data_size),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: list of line levels, each lasting exp_p cycles.
  function automatic void build_frame(input logic [7:0] d, input int ds, input int bp);
    int n;
`ifdef UART_TX_PARITY_EN
    bit par;
    par = 1'b0;
`endif
    n = (ds >= 5 && ds <= MAXB) ? ds : MAXB;
    exp_p = (bp < 2) ? 2 : bp;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
      par = par ^ d[i];
`endif
    end
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(par);
`endif
    exp_bits.push_back(1'b1);
  endfunction

  task automatic go(input logic [7:0] d, input logic [3:0] ds, input logic [13:0] bp);
    tx_data = d; data_size = ds; bit_period = bp; tx_start = 1'b1;
  endtask

  // Accept at the next rising edge, then check every cycle of the frame and the done cycle.
  task automatic run_frame(input logic [7:0] d, input int ds, input int bp,
                           input bit perturb, input bit hold, input string tag);
    build_frame(d, ds, bp);
    @(posedge clk);
    for (int b = 0; b < exp_bits.size(); b++) begin
      for (int c = 0; c < exp_p; c++) begin
        @(negedge clk);
        chk({tag, "_out"}, 32'(tx_out), 32'(exp_bits[b]));
        chk({tag, "_busy"}, 32'(tx_busy), 32'd1);
        chk({tag, "_done"}, 32'(tx_done), 32'd0);
        if (!hold) tx_start = perturb ? 1'($urandom_range(0, 1)) : 1'b0;
        if (perturb) begin
          tx_data = 8'($urandom);
          data_size = 4'($urandom);
          bit_period = 14'($urandom_range(0, 20));
        end
      end
    end
    @(negedge clk);
    chk({tag, "_end_out"}, 32'(tx_out), 32'd1);
    chk({tag, "_end_busy"}, 32'(tx_busy), 32'd0);
    chk({tag, "_end_done"}, 32'(tx_done), 32'd1);
    if (!hold) tx_start = 1'b0;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_idle_out"}, 32'(tx_out), 32'd1);
      chk({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
      chk({tag, "_idle_done"}, 32'(tx_done), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] rd;
    int rds, rbp;
    bit rpert;

    #2 n_rst = 1'b0;
    #1;
    chk("reset_out", 32'(tx_out), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_done", 32'(tx_done), 32'd0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    idle_check(2, "post_reset");

    go(8'hA5, 4'd8, 14'd10);  run_frame(8'hA5, 8, 10, 1'b0, 1'b0, "basic");  idle_check(3, "basic");
    go(8'hFF, 4'd5, 14'd4);   run_frame(8'hFF, 5, 4, 1'b0, 1'b0, "short");   idle_check(1, "short");
    go(8'h5C, 4'd12, 14'd3);  run_frame(8'h5C, 12, 3, 1'b0, 1'b0, "illegal_ds");
    go(8'h3C, 4'd8, 14'd0);   run_frame(8'h3C, 8, 0, 1'b0, 1'b0, "period0");
    go(8'hC3, 4'd6, 14'd1);   run_frame(8'hC3, 6, 1, 1'b0, 1'b0, "period1");
    idle_check(1, "period1");
    go(8'h96, 4'd7, 14'd5);   run_frame(8'h96, 7, 5, 1'b1, 1'b0, "perturb");
    idle_check(2, "perturb");

    go(8'h01, 4'd8, 14'd3);   run_frame(8'h01, 8, 3, 1'b0, 1'b1, "b2b_first");
    tx_data = 8'h80;          run_frame(8'h80, 8, 3, 1'b0, 1'b1, "b2b_second");
    tx_start = 1'b0;
    idle_check(2, "b2b");

    go(8'h07, 4'd8, 14'd2);   run_frame(8'h07, 8, 2, 1'b0, 1'b0, "par07");
    go(8'h03, 4'd8, 14'd2);   run_frame(8'h03, 8, 2, 1'b0, 1'b0, "par03");
    idle_check(1, "par");

    // Abandon a frame during DATA, while bit 1 of 8'hF0 (a 0) is on the line.
    go(8'hF0, 4'd8, 14'd10);
    @(posedge clk);
    @(negedge clk) tx_start = 1'b0;
    repeat (24) @(negedge clk);
    chk("midreset_pre_out", 32'(tx_out), 32'd0);
    #2 n_rst = 1'b0;
    #1;
    chk("midreset_out", 32'(tx_out), 32'd1);
    chk("midreset_busy", 32'(tx_busy), 32'd0);
    chk("midreset_done", 32'(tx_done), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("midreset_hold_done", 32'(tx_done), 32'd0);
      chk("midreset_hold_out", 32'(tx_out), 32'd1);
    end
    n_rst = 1'b1;
    idle_check(3, "after_reset");
    go(8'h5A, 4'd8, 14'd3);   run_frame(8'h5A, 8, 3, 1'b0, 1'b0, "clean");
    idle_check(1, "clean");

    for (int k = 0; k < 12; k++) begin
      rd = 8'($urandom);
      rds = int'($urandom_range(0, 15));
      rbp = int'($urandom_range(0, 8));
      rpert = 1'($urandom_range(0, 1));
      go(rd, 4'(rds), 14'(rbp));
      run_frame(rd, rds, rbp, rpert, 1'b0, "rand");
      idle_check(1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
